// File: rtl/isr_pipe_param.sv
// Iterative integer square root: leading-one scan, then one bit per trial with a pipelined squarer.
// Optional `ISR_REMAINDER_EN adds a remainder output (value - result^2).
module isr_pipe_param #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned MUL_STAGES = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   value,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] result
`ifdef ISR_REMAINDER_EN
  ,
  output logic [WIDTH/2:0]   remainder
`endif
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned RemW = HALF + 1;
  localparam int unsigned IdxW = $clog2(HALF);
  localparam int unsigned PosW = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(MUL_STAGES + 1);

  typedef enum logic [2:0] {StIdle, StScan, StFeed, StWait, StCheck, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  value_q, value_d;
  logic [HALF-1:0]   guess_q, guess_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [HALF-1:0]   result_q, result_d;
  logic [WIDTH-1:0]  prod_q [MUL_STAGES];
  logic [WIDTH-1:0]  prod_d [MUL_STAGES];
`ifdef ISR_REMAINDER_EN
  logic [WIDTH-1:0]  sq_q, sq_d;
  logic [RemW-1:0]   rem_q, rem_d;
`endif

  logic [HALF-1:0]   trial;
  logic [WIDTH-1:0]  square;
  logic [WIDTH-1:0]  product;
  logic              fits;
  logic [PosW-1:0]   msb;

  // Trial is stable from FEED through CHECK, so the free-running pipe holds a valid product in CHECK.
  assign trial   = guess_q | (HALF'(1) << idx_q);
  assign square  = WIDTH'(trial) * WIDTH'(trial);
  assign product = prod_q[MUL_STAGES-1];
  assign fits    = (product <= value_q);

  always_comb begin
    msb = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (value_q[i]) msb = PosW'(i);
    end
  end

  always_comb begin
    prod_d[0] = square;
    for (int unsigned s = 1; s < MUL_STAGES; s++) prod_d[s] = prod_q[s-1];
  end

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    guess_d  = guess_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef ISR_REMAINDER_EN
    sq_d     = sq_q;
    rem_d    = rem_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          value_d = value;
          guess_d = '0;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef ISR_REMAINDER_EN
          sq_d    = '0;
`endif
          state_d = StScan;
        end
      end
      StScan: begin
        if (value_q == '0) begin
          result_d = '0;
`ifdef ISR_REMAINDER_EN
          rem_d    = '0;
`endif
          state_d  = StDone;
        end else begin
          idx_d   = IdxW'(msb >> 1);
          state_d = StFeed;
        end
      end
      StFeed: begin
        cnt_d   = CntW'(MUL_STAGES);
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StCheck;
      end
      StCheck: begin
        if (fits) begin
          guess_d = trial;
`ifdef ISR_REMAINDER_EN
          sq_d    = product;
`endif
        end
        if (idx_q == '0) begin
          // Register the outcome on entry to DONE so result is valid while done is high.
          result_d = fits ? trial : guess_q;
`ifdef ISR_REMAINDER_EN
          rem_d    = RemW'(value_q - (fits ? product : sq_q));
`endif
          state_d  = StDone;
        end else begin
          idx_d   = idx_q - IdxW'(1);
          state_d = StFeed;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      value_q  <= '0;
      guess_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef ISR_REMAINDER_EN
      sq_q     <= '0;
      rem_q    <= '0;
`endif
      for (int unsigned s = 0; s < MUL_STAGES; s++) prod_q[s] <= '0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      guess_q  <= guess_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
`ifdef ISR_REMAINDER_EN
      sq_q     <= sq_d;
      rem_q    <= rem_d;
`endif
      for (int unsigned s = 0; s < MUL_STAGES; s++) prod_q[s] <= prod_d[s];
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
`ifdef ISR_REMAINDER_EN
  assign remainder = rem_q;
`endif

endmodule

// File: tb/tb_isr_pipe_param.sv
// Randomised bench for isr_pipe_param: a 64-bit/8-stage and a 16-bit/1-stage instance
// checked against a floating-point-seeded integer sqrt model and a closed-form latency.
module tb_isr_pipe_param;

  logic        clock;
  logic        reset;
  logic        start_a, start_b;
  logic [63:0] value_a;
  logic [15:0] value_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] result_a;
  logic [7:0]  result_b;
`ifdef ISR_REMAINDER_EN
  logic [32:0] rem_a;
  logic [8:0]  rem_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  isr_pipe_param #(.WIDTH(64), .MUL_STAGES(8)) u_dut_a (
    .clock  (clock),
    .reset  (reset),
    .start  (start_a),
    .value  (value_a),
    .busy   (busy_a),
    .done   (done_a),
    .result (result_a)
`ifdef ISR_REMAINDER_EN
    ,
    .remainder (rem_a)
`endif
  );

  isr_pipe_param #(.WIDTH(16), .MUL_STAGES(1)) u_dut_b (
    .clock  (clock),
    .reset  (reset),
    .start  (start_b),
    .value  (value_b),
    .busy   (busy_b),
    .done   (done_b),
    .result (result_b)
`ifdef ISR_REMAINDER_EN
    ,
    .remainder (rem_b)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference sqrt: real-valued estimate, then exact integer correction.
  function automatic logic [63:0] isqrt(input logic [63:0] v);
    real          rv;
    logic [127:0] r;
    logic [127:0] v128;
    rv   = real'(v[63:32]) * 4294967296.0 + real'(v[31:0]);
    r    = 128'(longint'($sqrt(rv)));
    v128 = 128'(v);
    for (int i = 0; i < 8 && r * r > v128; i++) r = r - 1;
    for (int i = 0; i < 8 && (r + 1) * (r + 1) <= v128; i++) r = r + 1;
    return r[63:0];
  endfunction

  // One trial per result bit that the operand can produce.
  function automatic int exp_latency(input logic [63:0] v, input int stages);
    int bitlen;
    if (v == 64'd0) return 2;
    bitlen = $clog2(128'(v) + 128'd1);
    return 2 + ((bitlen + 1) / 2) * (stages + 2);
  endfunction

  function automatic logic cur_busy(input bit b);
    return b ? busy_b : busy_a;
  endfunction

  function automatic logic cur_done(input bit b);
    return b ? done_b : done_a;
  endfunction

  function automatic logic [63:0] cur_result(input bit b);
    return b ? 64'(result_b) : 64'(result_a);
  endfunction

`ifdef ISR_REMAINDER_EN
  function automatic logic [63:0] cur_rem(input bit b);
    return b ? 64'(rem_b) : 64'(rem_a);
  endfunction
`endif

  task automatic drive(input bit b, input logic s, input logic [63:0] v);
    if (b) begin
      start_b = s;
      value_b = v[15:0];
    end else begin
      start_a = s;
      value_a = v;
    end
  endtask

  // Runs one operation; poke_cyc > 0 asserts a competing start in that busy cycle.
  task automatic run_op(input bit b, input logic [63:0] v_in, input int poke_cyc,
                        input logic [63:0] poke_v);
    logic [63:0] v;
    logic [63:0] r_exp;
    logic [63:0] prev_res;
    int          lat_exp;
    int          k;
    bit          busy_ok;
    bit          hold_ok;
    v        = b ? {48'd0, v_in[15:0]} : v_in;
    r_exp    = isqrt(v);
    lat_exp  = exp_latency(v, b ? 1 : 8);
    @(negedge clock);
    prev_res = cur_result(b);
    drive(b, 1'b1, v);
    @(negedge clock);
    drive(b, 1'b0, {$urandom, $urandom});
    k       = 1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!cur_done(b) && k < 700) begin
      if (!cur_busy(b)) busy_ok = 1'b0;
      if (cur_result(b) !== prev_res) hold_ok = 1'b0;
      if (k == poke_cyc) drive(b, 1'b1, poke_v);
      else drive(b, 1'b0, {$urandom, $urandom});
      @(negedge clock);
      k++;
    end
    drive(b, 1'b0, {$urandom, $urandom});
    check("latency", 128'(k), 128'(lat_exp));
    check("result", 128'(cur_result(b)), 128'(r_exp));
`ifdef ISR_REMAINDER_EN
    check("remainder", 128'(cur_rem(b)), 128'(v) - 128'(r_exp) * 128'(r_exp));
`endif
    check("busy_during_op", 128'(busy_ok), 128'd1);
    check("result_held", 128'(hold_ok), 128'd1);
    check("busy_in_done", 128'(cur_busy(b)), 128'd1);
    @(negedge clock);
    check("done_pulse", 128'(cur_done(b)), 128'd0);
    check("idle_after_done", 128'(cur_busy(b)), 128'd0);
    check("result_after_done", 128'(cur_result(b)), 128'(r_exp));
  endtask

  // Starts an operation and pulls reset at the given busy cycle (a WAIT cycle).
  task automatic reset_mid(input bit b, input logic [63:0] v, input int at_cyc);
    @(negedge clock);
    drive(b, 1'b1, v);
    @(negedge clock);
    drive(b, 1'b0, {$urandom, $urandom});
    for (int k = 1; k < at_cyc; k++) @(negedge clock);
    reset = 1'b1;
    drive(b, 1'b1, v);
    @(negedge clock);
    check("abort_busy", 128'(cur_busy(b)), 128'd0);
    check("abort_done", 128'(cur_done(b)), 128'd0);
    check("abort_result", 128'(cur_result(b)), 128'd0);
`ifdef ISR_REMAINDER_EN
    check("abort_remainder", 128'(cur_rem(b)), 128'd0);
`endif
    drive(b, 1'b0, 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    bit          b;
    logic [63:0] v;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    value_a = '0;
    value_b = '0;
    repeat (3) @(negedge clock);
    check("reset_busy_a", 128'(busy_a), 128'd0);
    check("reset_done_a", 128'(done_a), 128'd0);
    check("reset_result_a", 128'(result_a), 128'd0);
    check("reset_busy_b", 128'(busy_b), 128'd0);
    check("reset_done_b", 128'(done_b), 128'd0);
    check("reset_result_b", 128'(result_b), 128'd0);
    reset = 1'b0;

    run_op(1'b0, 64'd16, 0, 64'd0);
    run_op(1'b0, 64'd0, 0, 64'd0);
    run_op(1'b0, 64'd1, 0, 64'd0);
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0);
    run_op(1'b0, 64'd99, 0, 64'd0);
    run_op(1'b0, 64'd100, 0, 64'd0);
    run_op(1'b0, 64'd12345678, 7, 64'd5);
    reset_mid(1'b0, 64'hDEAD_BEEF_0123_4567, 5);
    run_op(1'b0, 64'h1234_5678_9ABC_DEF0, 0, 64'd0);
    run_op(1'b1, 64'd65535, 0, 64'd0);
    reset_mid(1'b1, 64'd40000, 3);
    run_op(1'b1, 64'd200, 4, 64'd9);

    for (int i = 0; i < 20; i++) begin
      b = 1'($urandom_range(0, 1));
      v = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_op(b, v, (i % 3 == 0) ? int'($urandom_range(1, 20)) : 0, {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/isr_pipe_param.md
Name: isr_pipe_param

Overview:
Parametrised iterative integer square root unit. Computes floor(sqrt(value)), the largest r with r*r <= value, for a WIDTH-bit unsigned operand. Uses bit-serial binary search with a leading-one pre-scan and an internal squarer of configurable pipeline latency. Successor to the fixed 64-bit ISR block: adds a start/busy handshake, parametrised width and latency, and a zero fast path.

Parameters:
WIDTH, 64, operand width in bits; must be even and >= 4; HALF = WIDTH/2 is the result width
MUL_STAGES, 8, squarer latency in cycles from FEED to product valid; must be >= 1

Ports:
clock  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high; clears FSM and all outputs
start  in  1  request; accepted only when busy=0 (state IDLE)
value  in  WIDTH  operand; sampled only on the accepted-start edge
busy   out  1  high in every state except IDLE
done   out  1  one-cycle pulse; result valid from this cycle onward
result out  HALF  floor(sqrt(value)); registered, held until the next DONE

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, result=0, internal guess/index/counter=0.
- States: IDLE, SCAN, FEED, WAIT, CHECK, DONE.
- IDLE: if start=1, latch value_q<=value, clear guess to 0, go to SCAN. Otherwise stay.
- SCAN (1 cycle): p = index of the highest set bit of value_q. If value_q==0, go to DONE with result 0. Else idx = p>>1, go to FEED.
- FEED (1 cycle): trial = guess | (1<<idx); launch trial*trial into the squarer (2*HALF-bit product, no truncation); load wait counter with MUL_STAGES.
- WAIT (MUL_STAGES cycles): decrement the counter; go to CHECK when it expires. The product is valid in CHECK.
- CHECK (1 cycle): if product <= value_q, then guess <= trial. If idx==0, go to DONE. Else idx <= idx-1 and go to FEED.
- DONE (1 cycle): result <= guess; done=1; go to IDLE. busy stays 1 during DONE.
- Latency: start accepted at edge T0 -> done high in cycle T0 + 2 + B*(MUL_STAGES+2), with B = idx_initial+1. For value=0, done is high in cycle T0+2.
- Worst case (WIDTH=64, MUL_STAGES=8): B=32, 322 cycles. This is below the 600-cycle budget.
- start while busy=1 is ignored. value changes while busy have no effect.
- start in the DONE cycle is ignored. It is accepted the following cycle (IDLE).
- Reset mid-operation aborts immediately: state=IDLE, done=0, busy=0, result=0. Reset wins over a simultaneous start.
- All comparisons are unsigned. The max operand (all ones) must give result=all ones in HALF bits, with no overflow of the trial square.

Optional Feature:
ISR_REMAINDER_EN:
- When defined, adds output port remainder, out, HALF+1 bits, equal to value_q - result*result.
- remainder is registered in DONE alongside result and cleared by reset.
- Implementation: keep the last accepted square from CHECK; subtract it from value_q in DONE (0 for value 0).
- When not defined, the port and its logic are absent and all other behaviour is identical.

Test Plan:
- WIDTH=64, MUL_STAGES=8, value=16, start 1 cycle -> done in cycle T0+32, result=4, busy high in cycles T0+1..T0+32. With ISR_REMAINDER_EN: remainder=0.
- value=0 -> done in cycle T0+2, result=0. value=1 -> result=1, done in cycle T0+12.
- value=64'hFFFF_FFFF_FFFF_FFFF -> result=32'hFFFF_FFFF, done in cycle T0+322. With ISR_REMAINDER_EN: remainder=33'h1_FFFF_FFFE.
- value=99 -> result=9 (remainder 18). Then a second start with value=100 -> result=10 (remainder 0). result holds 9 until the second done.
- start asserted mid-computation with another value -> ignored; the original result is returned at the original latency.
- reset asserted in WAIT -> next cycle busy=0, done=0, result=0. A new start then completes correctly. Repeat with WIDTH=16, MUL_STAGES=1, value=16'd65535 -> result=8'd255.
